// File: rtl/frame_diff_detector_if.sv
// ---------------------------------------------------------------------------
// frame_diff_detector_if
//   Pixel-stream bundle for frame_diff_detector.
//   master : the pixel source (frame-buffer read side). Drives per_* and
//            observes post_*.
//   slave  : the detector. Consumes per_* and drives post_*.
//   Signals:
//     per_frame_vsync  high for the whole frame
//     per_frame_href   high on active pixels
//     per_img_Y        NUM_FRAMES gray pixels, slot k at [k*DATA_W +: DATA_W]
//     post_frame_vsync vsync delayed to match the pixel pipeline
//     post_frame_href  href delayed to match the pixel pipeline
//     post_img_bin     0x00 = motion, all-ones = still
//   Stream semantics: there is no backpressure. Every clock with href high
//   carries one pixel; vsync/href frame it. Outputs keep that timing,
//   shifted by the fixed pipeline latency.
// ---------------------------------------------------------------------------
interface frame_diff_detector_if #(
    parameter int DATA_W     = 8,
    parameter int NUM_FRAMES = 3
);
    logic                         per_frame_vsync;
    logic                         per_frame_href;
    logic [NUM_FRAMES*DATA_W-1:0] per_img_Y;
    logic                         post_frame_vsync;
    logic                         post_frame_href;
    logic [DATA_W-1:0]            post_img_bin;

    modport master (
        output per_frame_vsync, per_frame_href, per_img_Y,
        input  post_frame_vsync, post_frame_href, post_img_bin
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_img_Y,
        output post_frame_vsync, post_frame_href, post_img_bin
    );
endinterface

// File: rtl/frame_diff_detector.sv
// ---------------------------------------------------------------------------
// frame_diff_detector
//   N-frame difference detector on the pixel clock. Orders NUM_FRAMES
//   time-aligned gray streams by age, takes absolute differences of adjacent
//   ages, thresholds them into a binary motion image and accumulates a
//   per-frame motion count and bounding box, published once per frame.
//
//   Ports:
//     clk, rst        pixel clock, synchronous active-high reset
//     vif (slave)     per_* pixel stream in, post_* binary stream out
//     newest_slot     slot holding the newest frame (>= NUM_FRAMES -> 0)
//     mode            0: newest pair only, 1: all adjacent pairs ANDed
//     threshold       difference threshold (strict >)
//     motion_cnt      motion pixel count of the last complete frame
//     box_*           bounding box of the last frame that had motion
//     box_valid       last complete frame had at least one motion pixel
//     frame_done      one-cycle pulse when the statistics update
//     gray_bypass     only with FRAME_DIFF_GRAY_BYPASS_EN: per pixel, output
//                     the newest gray pixel instead of the binary value
//
//   Optional macro: FRAME_DIFF_GRAY_BYPASS_EN
//   Pipeline latency: 3 cycles (S1 age order, S2 differences, S3 decision).
// ---------------------------------------------------------------------------
module frame_diff_detector #(
    parameter int DATA_W     = 8,
    parameter int NUM_FRAMES = 3,
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int CNT_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    frame_diff_detector_if.slave vif,
    input  logic [1:0]         newest_slot,
    input  logic               mode,
    input  logic [DATA_W-1:0]  threshold,
    output logic [CNT_W-1:0]   motion_cnt,
    output logic [10:0]        box_x_min,
    output logic [10:0]        box_x_max,
    output logic [10:0]        box_y_min,
    output logic [10:0]        box_y_max,
    output logic               box_valid,
    output logic               frame_done
`ifdef FRAME_DIFF_GRAY_BYPASS_EN
    ,
    input  logic               gray_bypass
`endif
);
    localparam int                ND       = NUM_FRAMES - 1;
    localparam logic [DATA_W-1:0] PIX_ONES = {DATA_W{1'b1}};
    localparam logic [10:0]       COL_LAST = 11'(IMG_HDISP - 1);
    localparam logic [10:0]       ROW_LAST = 11'(IMG_VDISP - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // ---------------- input qualification and slot ordering ----------------
    // After reset the input is ignored until vsync has been seen low, so a
    // frame cut by reset is never framed (and never published) downstream.
    logic              r_in_ok, r_vs_in_d;
    logic              w_vs_in, w_hs_in, w_vs_rise_in;
    logic [1:0]        r_newest, w_newest;
    logic              r_mode, w_mode;
    logic [DATA_W-1:0] w_age [NUM_FRAMES];

    always_comb begin
        int idx;
        idx          = 0;
        w_vs_in      = vif.per_frame_vsync & r_in_ok;
        w_hs_in      = vif.per_frame_href & r_in_ok;
        w_vs_rise_in = w_vs_in & ~r_vs_in_d;
        w_newest     = r_newest;
        w_mode       = r_mode;
        // The frame-start cycle already uses the freshly sampled values.
        if (w_vs_rise_in) begin
            w_newest = (int'(newest_slot) >= NUM_FRAMES) ? 2'd0 : newest_slot;
            w_mode   = mode;
        end
        for (int a = 0; a < NUM_FRAMES; a++) begin
            idx = int'(w_newest) - a;
            if (idx < 0) idx = idx + NUM_FRAMES;
            w_age[a] = vif.per_img_Y[idx*DATA_W +: DATA_W];
        end
    end

    // ---------------- pipeline registers ----------------
    logic [DATA_W-1:0] r_s1_p [NUM_FRAMES];
    logic              r_s1_vs, r_s1_hs, r_s1_mode;
    logic [DATA_W-1:0] r_s2_d [ND];
    logic              r_s2_vs, r_s2_hs, r_s2_mode;
    logic              r_post_vs, r_post_hs, r_s3_motion;
    logic [DATA_W-1:0] r_post_bin;
    logic              w_all, w_motion;
    logic [DATA_W-1:0] w_bin;
`ifdef FRAME_DIFF_GRAY_BYPASS_EN
    logic              r_s1_byp, r_s2_byp;
    logic [DATA_W-1:0] r_s2_p0;
`endif

    // S3 decision: threshold is applied combinationally here.
    always_comb begin
        w_all = 1'b1;
        for (int a = 0; a < ND; a++) w_all = w_all & (r_s2_d[a] > threshold);
        w_motion = r_s2_mode ? w_all : (r_s2_d[0] > threshold);
        w_bin    = (r_s2_hs && w_motion) ? '0 : PIX_ONES;
`ifdef FRAME_DIFF_GRAY_BYPASS_EN
        if (r_s2_byp) w_bin = r_s2_p0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ok     <= 1'b0;
            r_vs_in_d   <= 1'b0;
            r_newest    <= '0;
            r_mode      <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s2_vs     <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_post_vs   <= 1'b0;
            r_post_hs   <= 1'b0;
            r_s3_motion <= 1'b0;
            r_post_bin  <= PIX_ONES;
            for (int a = 0; a < NUM_FRAMES; a++) r_s1_p[a] <= '0;
            for (int a = 0; a < ND; a++) r_s2_d[a] <= '0;
`ifdef FRAME_DIFF_GRAY_BYPASS_EN
            r_s1_byp    <= 1'b0;
            r_s2_byp    <= 1'b0;
            r_s2_p0     <= '0;
`endif
        end else begin
            if (!vif.per_frame_vsync) r_in_ok <= 1'b1;
            r_vs_in_d <= w_vs_in;
            r_newest  <= w_newest;
            r_mode    <= w_mode;
            // S1: age-ordered pixels
            for (int a = 0; a < NUM_FRAMES; a++) r_s1_p[a] <= w_age[a];
            r_s1_vs   <= w_vs_in;
            r_s1_hs   <= w_hs_in;
            r_s1_mode <= w_mode;
            // S2: adjacent-age absolute differences
            for (int a = 0; a < ND; a++)
                r_s2_d[a] <= (r_s1_p[a] > r_s1_p[a+1]) ? (r_s1_p[a] - r_s1_p[a+1])
                                                       : (r_s1_p[a+1] - r_s1_p[a]);
            r_s2_vs   <= r_s1_vs;
            r_s2_hs   <= r_s1_hs;
            r_s2_mode <= r_s1_mode;
            // S3: binary output
            r_post_vs   <= r_s2_vs;
            r_post_hs   <= r_s2_hs;
            r_s3_motion <= r_s2_hs & w_motion;
            r_post_bin  <= w_bin;
`ifdef FRAME_DIFF_GRAY_BYPASS_EN
            r_s1_byp    <= gray_bypass;
            r_s2_byp    <= r_s1_byp;
            r_s2_p0     <= r_s1_p[0];
`endif
        end
    end

    assign vif.post_frame_vsync = r_post_vs;
    assign vif.post_frame_href  = r_post_hs;
    assign vif.post_img_bin     = r_post_bin;

    // ---------------- statistics on the S3-aligned stream ----------------
    logic              r_s3_vs_d, r_s3_hs_d, r_armed;
    logic [10:0]       r_col, r_row;
    logic [CNT_W-1:0]  r_cnt;
    logic [10:0]       r_xmin, r_xmax, r_ymin, r_ymax;
    logic [CNT_W-1:0]  r_motion_cnt;
    logic [10:0]       r_bx_min, r_bx_max, r_by_min, r_by_max;
    logic              r_box_valid, r_frame_done;
    logic              w_s3_vs_rise, w_s3_vs_fall, w_s3_hs_fall;

    assign w_s3_vs_rise = r_post_vs & ~r_s3_vs_d;
    assign w_s3_vs_fall = ~r_post_vs & r_s3_vs_d;
    assign w_s3_hs_fall = ~r_post_hs & r_s3_hs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_vs_d    <= 1'b0;
            r_s3_hs_d    <= 1'b0;
            r_armed      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_xmin       <= '0;
            r_xmax       <= '0;
            r_ymin       <= '0;
            r_ymax       <= '0;
            r_motion_cnt <= '0;
            r_bx_min     <= '0;
            r_bx_max     <= '0;
            r_by_min     <= '0;
            r_by_max     <= '0;
            r_box_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s3_vs_d    <= r_post_vs;
            r_s3_hs_d    <= r_post_hs;
            r_frame_done <= 1'b0;
            if (w_s3_vs_rise) r_armed <= 1'b1;

            if (r_post_hs) begin
                if (r_col != COL_LAST) r_col <= r_col + 11'd1;
            end else begin
                r_col <= '0;
            end

            if (w_s3_vs_rise)
                r_row <= '0;
            else if (w_s3_hs_fall && r_row != ROW_LAST)
                r_row <= r_row + 11'd1;

            // Publish wins over accumulation; a motion pixel on the
            // vsync falling edge is dropped.
            if (w_s3_vs_fall && r_armed) begin
                r_motion_cnt <= r_cnt;
                r_box_valid  <= (r_cnt != '0);
                if (r_cnt != '0) begin
                    r_bx_min <= r_xmin;
                    r_bx_max <= r_xmax;
                    r_by_min <= r_ymin;
                    r_by_max <= r_ymax;
                end
                r_frame_done <= 1'b1;
                r_cnt  <= '0;
                r_xmin <= '0;
                r_xmax <= '0;
                r_ymin <= '0;
                r_ymax <= '0;
            end else if (r_post_hs && r_s3_motion) begin
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_ONE;
                if (r_cnt == '0) begin
                    r_xmin <= r_col;
                    r_xmax <= r_col;
                    r_ymin <= r_row;
                    r_ymax <= r_row;
                end else begin
                    if (r_col < r_xmin) r_xmin <= r_col;
                    if (r_col > r_xmax) r_xmax <= r_col;
                    if (r_row < r_ymin) r_ymin <= r_row;
                    if (r_row > r_ymax) r_ymax <= r_row;
                end
            end
        end
    end

    assign motion_cnt = r_motion_cnt;
    assign box_x_min  = r_bx_min;
    assign box_x_max  = r_bx_max;
    assign box_y_min  = r_by_min;
    assign box_y_max  = r_by_max;
    assign box_valid  = r_box_valid;
    assign frame_done = r_frame_done;
endmodule
